// File: rtl/sim_exit_monitor.sv
// Simulation exit monitor: watches harness completion, tohost writes, timeout and
// liveness, latches a cause-coded result, drains, then pulses a single finish request.
module sim_exit_monitor #(
  parameter int CYCLE_W      = 64,
  parameter int DRAIN_CYCLES = 16,
  parameter int EXIT_W       = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               harness_reset,
  input  logic [CYCLE_W-1:0] max_cycles,
  input  logic [CYCLE_W-1:0] watchdog_limit,
  input  logic               io_success,
  input  logic               tohost_valid,
  input  logic [63:0]        tohost_data,
  input  logic               heartbeat,
  output logic               running,
  output logic               done,
  output logic               finish_req,
  output logic               pass,
  output logic [1:0]         cause,
  output logic               hang,
  output logic [EXIT_W-1:0]  exit_code,
  output logic [CYCLE_W-1:0] cycle_count,
  output logic [1:0]         dbg_state
);

  localparam int DCNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_CYCLES);

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_SUCCESS = 2'd1;
  localparam logic [1:0] CAUSE_TOHOST  = 2'd2;
  localparam logic [1:0] CAUSE_LIMIT   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_running;
  logic               r_done;
  logic               r_finish;
  logic               r_pass;
  logic [1:0]         r_cause;
  logic               r_hang;
  logic [EXIT_W-1:0]  r_exit_code;
  logic [CYCLE_W-1:0] r_cycle_count;
  logic [CYCLE_W-1:0] r_idle_count;
  logic [DCNT_W-1:0]  r_drain_cnt;

  logic [CYCLE_W-1:0] w_cycle_next;
  logic [CYCLE_W-1:0] w_idle_cur;
  logic [CYCLE_W-1:0] w_idle_next;
  logic               w_ev_success;
  logic               w_ev_tohost;
  logic               w_ev_timeout;
  logic               w_ev_hang;
  logic               w_exit;
  logic [EXIT_W-1:0]  w_tohost_code;
  logic [1:0]         w_cause;
  logic               w_hang;
  logic               w_pass;
  logic [EXIT_W-1:0]  w_exit_code;
  logic               w_unused;

  // Counters saturate rather than wrap so a huge run can never alias a limit.
  assign w_cycle_next = (&r_cycle_count) ? r_cycle_count : r_cycle_count + 1'b1;

  // A heartbeat in this cycle zeroes the idle count before the watchdog compare.
  assign w_idle_cur  = heartbeat ? '0 : r_idle_count;
  assign w_idle_next = (&w_idle_cur) ? w_idle_cur : w_idle_cur + 1'b1;

  assign w_ev_success  = io_success;
  assign w_ev_tohost   = tohost_valid & tohost_data[0];
  assign w_ev_timeout  = (max_cycles != '0) && (r_cycle_count == max_cycles);
  assign w_ev_hang     = (watchdog_limit != '0) && (w_idle_cur == watchdog_limit);
  assign w_exit        = w_ev_success | w_ev_tohost | w_ev_timeout | w_ev_hang;
  assign w_tohost_code = tohost_data[EXIT_W:1];
  assign w_unused      = ^tohost_data;

  always_comb begin
    w_cause     = CAUSE_NONE;
    w_hang      = 1'b0;
    w_pass      = 1'b0;
    w_exit_code = '0;
    if (w_ev_success) begin
      w_cause     = CAUSE_SUCCESS;
      w_pass      = 1'b1;
    end else if (w_ev_tohost) begin
      w_cause     = CAUSE_TOHOST;
      w_exit_code = w_tohost_code;
      w_pass      = (w_tohost_code == '0);
    end else if (w_ev_timeout) begin
      w_cause     = CAUSE_LIMIT;
      w_exit_code = EXIT_W'(1);
    end else if (w_ev_hang) begin
      w_cause     = CAUSE_LIMIT;
      w_hang      = 1'b1;
      w_exit_code = EXIT_W'(2);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_running     <= 1'b0;
      r_done        <= 1'b0;
      r_finish      <= 1'b0;
      r_pass        <= 1'b0;
      r_cause       <= CAUSE_NONE;
      r_hang        <= 1'b0;
      r_exit_code   <= '0;
      r_cycle_count <= '0;
      r_idle_count  <= '0;
      r_drain_cnt   <= '0;
    end else begin
      r_finish <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!harness_reset) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
          end
        end
        S_RUN: begin
          if (harness_reset) begin
            r_state       <= S_IDLE;
            r_running     <= 1'b0;
            r_cycle_count <= '0;
            r_idle_count  <= '0;
            r_cause       <= CAUSE_NONE;
            r_hang        <= 1'b0;
            r_pass        <= 1'b0;
            r_exit_code   <= '0;
          end else begin
            r_cycle_count <= w_cycle_next;
            r_idle_count  <= w_idle_next;
            if (w_exit) begin
              r_state     <= S_DRAIN;
              r_running   <= 1'b0;
              r_cause     <= w_cause;
              r_hang      <= w_hang;
              r_pass      <= w_pass;
              r_exit_code <= w_exit_code;
              r_drain_cnt <= '0;
            end
          end
        end
        S_DRAIN: begin
          // Results are frozen here; only time passes until the finish pulse.
          r_cycle_count <= w_cycle_next;
          if (r_drain_cnt == DRAIN_LAST) begin
            r_state  <= S_DONE;
            r_done   <= 1'b1;
            r_finish <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_done <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign running     = r_running;
  assign done        = r_done;
  assign finish_req  = r_finish;
  assign pass        = r_pass;
  assign cause       = r_cause;
  assign hang        = r_hang;
  assign exit_code   = r_exit_code;
  assign cycle_count = r_cycle_count;
  assign dbg_state   = r_state;

endmodule
